// File: rtl/mealy_fsm.sv
// Mealy detector for the serial pattern 1-0-1-1 (oldest bit first), one bit per clock.
// Optional saturating match counter is built when MATCH_COUNT_EN is defined.
module mealy_fsm #(
    parameter int OVERLAP = 1
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       in,
    output logic       out,
`ifdef MATCH_COUNT_EN
    output logic [7:0] match_count,
`endif
    output logic [1:0] o_dbg_state
);

    // Stream interface: no valid/ready; every rising edge consumes `in`,
    // and `out` is meaningful only just before that edge.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_match;

    always_ff @(posedge clk) begin
        if (arstn) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S0: w_next_state = in ? S1 : S0;
            S1: w_next_state = in ? S1 : S2;
            S2: w_next_state = in ? S3 : S0;
            S3: begin
                if (!in) begin
                    w_next_state = S2;
                end else if (OVERLAP != 0) begin
                    w_next_state = S1;
                end else begin
                    w_next_state = S0;
                end
            end
            default: w_next_state = S0;
        endcase
    end

    // Reset masks the flag even when the register still holds S3.
    assign w_match     = (r_state == S3) && in && !arstn;
    assign out         = w_match;
    assign o_dbg_state = r_state;

`ifdef MATCH_COUNT_EN
    logic [7:0] r_match_count;

    always_ff @(posedge clk) begin
        if (arstn) begin
            r_match_count <= 8'd0;
        end else if (w_match && (r_match_count != 8'hFF)) begin
            r_match_count <= r_match_count + 8'd1;
        end
    end

    assign match_count = r_match_count;
`endif

endmodule

// File: tb/tb_mealy_fsm.sv
// Bench for mealy_fsm: overlapping and non-overlapping instances share one stimulus stream.
// Covers the MATCH_COUNT_EN counter when that macro is defined.
module tb_mealy_fsm;

    logic       clk;
    logic       arstn;
    logic       in;
    logic       out_ov1;
    logic       out_ov0;
    logic [1:0] state_ov1;
    logic [1:0] state_ov0;
`ifdef MATCH_COUNT_EN
    logic [7:0] cnt_ov1;
    logic [7:0] cnt_ov0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {expected out of OVERLAP=1 instance, expected out of OVERLAP=0 instance}
    logic [1:0] exp_q[$];

    mealy_fsm #(.OVERLAP(1)) u_dut_ov1 (
        .clk        (clk),
        .arstn      (arstn),
        .in         (in),
        .out        (out_ov1),
`ifdef MATCH_COUNT_EN
        .match_count(cnt_ov1),
`endif
        .o_dbg_state(state_ov1)
    );

    mealy_fsm #(.OVERLAP(0)) u_dut_ov0 (
        .clk        (clk),
        .arstn      (arstn),
        .in         (in),
        .out        (out_ov0),
`ifdef MATCH_COUNT_EN
        .match_count(cnt_ov0),
`endif
        .o_dbg_state(state_ov0)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation time %0t exceeded, required completion before 200000", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Driver: called just after a falling edge; drives, checks the Mealy output,
    // then returns at the next falling edge (one rising edge consumed).
    task automatic step(input string tag, input logic b, input logic rst,
                        input logic e1, input logic e0);
        logic [1:0] exp;
        in    = b;
        arstn = rst;
        exp_q.push_back({e1, e0});
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        assert (out_ov1 === exp[1]) else begin
            n_fail++;
            $error("FAIL %s ov1: out=%b expected=%b", tag, out_ov1, exp[1]);
        end
        n_checks++;
        assert (out_ov0 === exp[0]) else begin
            n_fail++;
            $error("FAIL %s ov0: out=%b expected=%b", tag, out_ov0, exp[0]);
        end
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [1:0] e1, input logic [1:0] e0);
        n_checks++;
        assert (state_ov1 === e1) else begin
            n_fail++;
            $error("FAIL %s state ov1: got %0d expected %0d", tag, state_ov1, e1);
        end
        n_checks++;
        assert (state_ov0 === e0) else begin
            n_fail++;
            $error("FAIL %s state ov0: got %0d expected %0d", tag, state_ov0, e0);
        end
    endtask

`ifdef MATCH_COUNT_EN
    task automatic check_count(input string tag, input logic [7:0] e);
        n_checks++;
        assert (cnt_ov1 === e) else begin
            n_fail++;
            $error("FAIL %s count ov1: got %0d expected %0d", tag, cnt_ov1, e);
        end
        n_checks++;
        assert (cnt_ov0 === e) else begin
            n_fail++;
            $error("FAIL %s count ov0: got %0d expected %0d", tag, cnt_ov0, e);
        end
    endtask
`endif

    // Reset, then apply a bit string (first char first) with per-bit expected flags.
    task automatic run_seq(input string tag, input string bits, input string e1, input string e0);
        step({tag, "_rst"}, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < bits.len(); i++) begin
            step($sformatf("%s_b%0d", tag, i + 1), bits[i] == "1", 1'b0,
                 e1[i] == "1", e0[i] == "1");
        end
    endtask

    initial begin
        arstn = 1'b1;
        in    = 1'b0;
        @(negedge clk);

        // Reset held 3 edges with in=1: flag masked, state S0
        for (int i = 0; i < 3; i++) begin
            step($sformatf("reset_hold%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            check_state("reset_hold", 2'd0, 2'd0);
        end
`ifdef MATCH_COUNT_EN
        check_count("reset_cnt", 8'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            step($sformatf("zeros%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_state("zeros", 2'd0, 2'd0);

        run_seq("basic",     "1011",     "0001",     "0001");
        run_seq("overlap",   "1011011",  "0001001",  "0001000");
        run_seq("restart",   "10111011", "00010001", "00010001");
        run_seq("s1_loop",   "11011",    "00001",    "00001");
        run_seq("s2_zero",   "1001011",  "0000001",  "0000001");
        run_seq("s3_zero",   "101011",   "000001",   "000001");

        // Reset mid-pattern: reach S3, then reset with in=1 must not flag
        run_seq("mid", "101", "000", "000");
        check_state("mid_s3", 2'd3, 2'd3);
        step("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        check_state("mid_after_rst", 2'd0, 2'd0);
        step("mid_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        step("mid_b2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("mid_b3", 1'b1, 1'b0, 1'b0, 1'b0);
        step("mid_b4", 1'b1, 1'b0, 1'b1, 1'b1);

`ifdef MATCH_COUNT_EN
        // 300 repetitions of 1011: both instances match once per repetition
        step("cnt_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 300; r++) begin
            check_count($sformatf("cnt_rep%0d", r), (r > 255) ? 8'd255 : 8'(r));
            step("cnt_b1", 1'b1, 1'b0, 1'b0, 1'b0);
            step("cnt_b2", 1'b0, 1'b0, 1'b0, 1'b0);
            step("cnt_b3", 1'b1, 1'b0, 1'b0, 1'b0);
            step("cnt_b4", 1'b1, 1'b0, 1'b1, 1'b1);
        end
        check_count("cnt_sat", 8'd255);
        step("cnt_clr", 1'b1, 1'b1, 1'b0, 1'b0);
        check_count("cnt_clr", 8'd0);
`endif

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drain: size=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
